pc_branch_unit: RTL and testbench
=================================

// Module: pc_branch_unit
// PURPOSE
//  Program-counter register and next-PC sequencer for the MIPS core. Consumes the
//  32-bit compare word from the ALU comparison stage (0 = operands equal, 1 = not
//  equal), resolves beq/bne/j/jr, and handshakes each fetch with instruction memory.
//  Traps on a misaligned jr target.
// PARAMETERS
//  WIDTH     32            address/data width
//  RESET_PC  32'h0000_0000 PC value loaded on reset
// PORTS
//  clk          in   1      single clock, rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  branch_eq    in   1      current instr is beq
//  branch_ne    in   1      current instr is bne
//  jump         in   1      current instr is j
//  jump_reg     in   1      current instr is jr
//  cmp_result   in   WIDTH  compare word: 0 = equal, nonzero = not equal
//  imm_ext      in   WIDTH  sign-extended 16-bit branch offset (words)
//  jump_index   in   26     j-type index field
//  reg_target   in   WIDTH  rs value for jr
//  stall        in   1      downstream hold; PC must not advance
//  fetch_ack    in   1      imem has returned the instruction at pc
//  fetch_req    out  1      request fetch at pc
//  pc           out  WIDTH  current PC
//  pc_plus4     out  WIDTH  pc + 4 (combinational, mod 2^WIDTH)
//  branch_taken out  1      registered: last PC update was a taken branch/jump
//  misaligned   out  1      sticky: jr target had [1:0] != 0
// BEHAVIOUR
//  Reset (reset_n low, async): pc=RESET_PC, fetch_req=0, branch_taken=0,
//   misaligned=0, state=BOOT. Reset mid-fetch aborts; no PC update that cycle.
//  States: BOOT, FETCH, HOLD, TRAP.
//   BOOT : fetch_req=0; next cycle -> FETCH (one dead cycle after reset release).
//   FETCH: fetch_req=1. If fetch_ack & !stall: pc<=next_pc, stay FETCH.
//          If fetch_ack & stall: pc held -> HOLD. If !fetch_ack: pc held, stay.
//   HOLD : fetch_req=0, pc held. When !stall: pc<=next_pc -> FETCH.
//   TRAP : fetch_req=0, pc frozen, misaligned=1; leave only via reset.
//  next_pc priority (one-hot decode not assumed):
//   jump_reg > jump > taken branch > pc_plus4.
//   jump_reg : reg_target; if reg_target[1:0]!=0 do NOT update pc, set
//              misaligned, -> TRAP (evaluated when the update would occur).
//   jump     : {pc_plus4[31:28], jump_index, 2'b00}.
//   taken    : (branch_eq & cmp_result==0) | (branch_ne & cmp_result!=0);
//              target = pc_plus4 + (imm_ext << 2), truncated to WIDTH.
//   branch_eq & branch_ne both set: taken iff either condition holds.
//  branch_taken updated only on a PC update: 1 if source was jr/j/taken branch,
//   else 0; held otherwise.
//  No delay slot: target is fetched immediately after the branch.
//  Arithmetic wraps: pc 0xFFFF_FFFC sequential -> 0x0000_0000.
//  Latency: control inputs sampled on the update edge; new pc visible next cycle.
// TESTING
//  Reset release -> pc=0, fetch_req=0 for 1 cycle, then 1; branch_taken=0.
//  fetch_ack held high, no branch -> pc 0x0,0x4,0x8 on consecutive cycles.
//  pc=0x8, branch_eq, cmp_result=0, imm_ext=3, ack -> pc=0x18, branch_taken=1;
//   same with cmp_result=1 -> pc=0xC, branch_taken=0.
//  pc=0x18, branch_ne, cmp_result=1, imm_ext=0xFFFF_FFFF -> pc=0x18 (self-loop).
//  jump, jump_index=0x100 at pc=0x4 -> pc=0x400; jump_reg+jump, reg_target=0x2000
//   -> pc=0x2000 (jr wins).
//  ack+stall 3 cycles -> HOLD, fetch_req=0, pc frozen; stall drop -> update, FETCH;
//   jr reg_target=0x1002 -> misaligned=1, TRAP, pc unchanged until reset_n low.

Source files
------------

// File: rtl/pc_branch_unit_if.sv
// Fetch/branch bus between the next-PC sequencer and its neighbours:
// decoded control and operands in, fetch request and PC state out.
interface pc_branch_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic              branch_eq;
  logic              branch_ne;
  logic              jump;
  logic              jump_reg;
  logic [WIDTH-1:0]  cmp_result;
  logic [WIDTH-1:0]  imm_ext;
  logic [25:0]       jump_index;
  logic [WIDTH-1:0]  reg_target;
  logic              stall;
  logic              fetch_ack;
  logic              fetch_req;
  logic [WIDTH-1:0]  pc;
  logic [WIDTH-1:0]  pc_plus4;
  logic              branch_taken;
  logic              misaligned;

  modport master (
    output branch_eq, branch_ne, jump, jump_reg, cmp_result, imm_ext,
           jump_index, reg_target, stall, fetch_ack,
    input  fetch_req, pc, pc_plus4, branch_taken, misaligned
  );

  modport slave (
    input  branch_eq, branch_ne, jump, jump_reg, cmp_result, imm_ext,
           jump_index, reg_target, stall, fetch_ack,
    output fetch_req, pc, pc_plus4, branch_taken, misaligned
  );
endinterface

// File: rtl/pc_branch_unit.sv
// Program counter and next-PC sequencer: resolves beq/bne/j/jr, handshakes
// each fetch with instruction memory and traps on a misaligned jr target.
module pc_branch_unit #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  pc_branch_unit_if.slave bus
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, TRAP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             fetch_req_q, fetch_req_d;
  logic             taken_q, taken_d;
  logic             mis_q, mis_d;

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] next_pc;
  logic             br_taken;
  logic             redirect;
  logic             jr_bad;
  logic             update;

  always_comb pc_plus4 = pc_q + WIDTH'(4);

  // Redirect source decode; jr beats j beats a taken conditional branch.
  always_comb begin
    br_taken = (bus.branch_eq && (bus.cmp_result == '0)) ||
               (bus.branch_ne && (bus.cmp_result != '0));
    redirect = bus.jump_reg || bus.jump || br_taken;
    jr_bad   = bus.jump_reg && (bus.reg_target[1:0] != 2'b00);
    if (bus.jump_reg) begin
      next_pc = bus.reg_target;
    end else if (bus.jump) begin
      next_pc = {pc_plus4[WIDTH-1:28], bus.jump_index, 2'b00};
    end else if (br_taken) begin
      next_pc = pc_plus4 + (bus.imm_ext << 2);
    end else begin
      next_pc = pc_plus4;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = taken_q;
    mis_d   = mis_q;
    update  = 1'b0;
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: begin
        if (bus.fetch_ack) begin
          if (bus.stall) state_d = HOLD;
          else           update  = 1'b1;
        end
      end
      HOLD:  update = !bus.stall;
      TRAP:  state_d = TRAP;
      default: state_d = BOOT;
    endcase
    // A bad jr target is caught at the edge where the PC would have moved.
    if (update) begin
      if (jr_bad) begin
        state_d = TRAP;
        mis_d   = 1'b1;
      end else begin
        pc_d    = next_pc;
        taken_d = redirect;
        state_d = FETCH;
      end
    end
    fetch_req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      fetch_req_q <= 1'b0;
      taken_q     <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_req_q <= fetch_req_d;
      taken_q     <= taken_d;
      mis_q       <= mis_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.fetch_req    = fetch_req_q;
  assign bus.branch_taken = taken_q;
  assign bus.misaligned   = mis_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed and randomized checks of pc_branch_unit against a cycle-level
// behavioural model of the fetch/branch rules.
module tb_pc_branch_unit;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  pc_branch_unit_if #(.WIDTH(32)) bus ();

  pc_branch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: what the sequencer should be doing in plain terms.
  logic [31:0] m_pc;
  bit          m_boot, m_held, m_trap, m_bt, m_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},           bus.pc,                   m_pc);
    chk({tag, ".pc_plus4"},     bus.pc_plus4,             m_pc + 32'd4);
    chk({tag, ".fetch_req"},    {31'b0, bus.fetch_req},   {31'b0, !(m_boot || m_held || m_trap)});
    chk({tag, ".branch_taken"}, {31'b0, bus.branch_taken}, {31'b0, m_bt});
    chk({tag, ".misaligned"},   {31'b0, bus.misaligned},  {31'b0, m_mis});
  endtask

  task automatic model_reset();
    m_pc   = 32'h0;
    m_boot = 1'b1;
    m_held = 1'b0;
    m_trap = 1'b0;
    m_bt   = 1'b0;
    m_mis  = 1'b0;
  endtask

  // Called at posedge+1; reset lands between edges, released after one edge.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    model_reset();
    #3;
    check_all({tag, ".in_reset"});
    @(posedge clk);
    #1;
    check_all({tag, ".held_reset"});
    reset_n = 1'b1;
    #1;
    check_all({tag, ".released"});
  endtask

  task automatic step(input string tag, input bit beq, input bit bne, input bit j, input bit jr,
                      input logic [31:0] cmp, input logic [31:0] imm, input logic [25:0] jidx,
                      input logic [31:0] rt, input bit stl, input bit ack);
    bit upd, tk;
    bus.branch_eq  = beq;
    bus.branch_ne  = bne;
    bus.jump       = j;
    bus.jump_reg   = jr;
    bus.cmp_result = cmp;
    bus.imm_ext    = imm;
    bus.jump_index = jidx;
    bus.reg_target = rt;
    bus.stall      = stl;
    bus.fetch_ack  = ack;
    @(posedge clk);
    if (!m_trap) begin
      if (m_boot) begin
        m_boot = 1'b0;
      end else begin
        upd = m_held ? !stl : (ack && !stl);
        if (!m_held && ack && stl) m_held = 1'b1;
        if (upd) begin
          m_held = 1'b0;
          if (jr) begin
            if (rt % 32'd4 != 32'd0) begin
              m_trap = 1'b1;
              m_mis  = 1'b1;
            end else begin
              m_pc = rt;
              m_bt = 1'b1;
            end
          end else if (j) begin
            m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'b0, jidx} * 32'd4);
            m_bt = 1'b1;
          end else begin
            tk   = (beq && cmp == 32'd0) || (bne && cmp != 32'd0);
            m_pc = tk ? (m_pc + 32'd4 + imm * 32'd4) : (m_pc + 32'd4);
            m_bt = tk;
          end
        end
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic seq(input string tag, input bit stl, input bit ack);
    step(tag, 0, 0, 0, 0, 32'h0, 32'h0, 26'h0, 32'h0, stl, ack);
  endtask

  initial begin
    logic [31:0] rt, cmp;
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    bus.branch_eq = 0; bus.branch_ne = 0; bus.jump = 0; bus.jump_reg = 0;
    bus.cmp_result = '0; bus.imm_ext = '0; bus.jump_index = '0; bus.reg_target = '0;
    bus.stall = 0; bus.fetch_ack = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset("por");
    chk("boot_fetch_req_low", {31'b0, bus.fetch_req}, 32'd0);

    seq("boot_exit", 0, 0);
    chk("fetch_req_high", {31'b0, bus.fetch_req}, 32'd1);
    seq("no_ack", 0, 0);
    seq("seq0", 0, 1);
    chk("seq_pc4", bus.pc, 32'h4);
    seq("seq1", 0, 1);
    chk("seq_pc8", bus.pc, 32'h8);

    step("beq_taken", 1, 0, 0, 0, 32'h0, 32'd3, 26'h0, 32'h0, 0, 1);
    chk("beq_taken_pc", bus.pc, 32'h18);
    chk("beq_taken_bt", {31'b0, bus.branch_taken}, 32'd1);
    step("bne_selfloop", 0, 1, 0, 0, 32'h1, 32'hFFFF_FFFF, 26'h0, 32'h0, 0, 1);
    chk("selfloop_pc", bus.pc, 32'h18);
    step("jr_to8", 0, 0, 0, 1, 32'h0, 32'h0, 26'h0, 32'h8, 0, 1);
    step("beq_not_taken", 1, 0, 0, 0, 32'h1, 32'd3, 26'h0, 32'h0, 0, 1);
    chk("beq_nt_pc", bus.pc, 32'hC);
    chk("beq_nt_bt", {31'b0, bus.branch_taken}, 32'd0);
    step("both_br", 1, 1, 0, 0, 32'h5, 32'd1, 26'h0, 32'h0, 0, 1);
    step("jr_to4", 0, 0, 0, 1, 32'h0, 32'h0, 26'h0, 32'h4, 0, 1);
    step("jump", 0, 0, 1, 0, 32'h0, 32'h0, 26'h100, 32'h0, 0, 1);
    chk("jump_pc", bus.pc, 32'h400);
    step("jr_over_j", 0, 0, 1, 1, 32'h0, 32'h0, 26'h3, 32'h2000, 0, 1);
    chk("jr_wins_pc", bus.pc, 32'h2000);

    seq("stall0", 1, 1);
    chk("hold_fetch_req", {31'b0, bus.fetch_req}, 32'd0);
    seq("stall1", 1, 1);
    seq("stall2", 1, 0);
    chk("hold_pc", bus.pc, 32'h2000);
    seq("unstall", 0, 0);
    chk("unstall_pc", bus.pc, 32'h2004);
    step("jr_misaligned", 0, 0, 0, 1, 32'h0, 32'h0, 26'h0, 32'h1002, 0, 1);
    chk("trap_mis", {31'b0, bus.misaligned}, 32'd1);
    seq("trap0", 0, 1);
    seq("trap1", 0, 1);
    chk("trap_pc", bus.pc, 32'h2004);

    do_reset("after_trap");
    seq("wrap_boot", 0, 1);
    step("jr_top", 0, 0, 0, 1, 32'h0, 32'h0, 26'h0, 32'hFFFF_FFFC, 0, 1);
    seq("wrap", 0, 1);
    chk("wrap_pc", bus.pc, 32'h0);
    seq("mid0", 0, 1);
    do_reset("mid_fetch");

    for (int i = 0; i < 600; i++) begin
      if ((m_trap && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
        do_reset("rand_reset");
      end else begin
        rt  = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
        cmp = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
        step("rand",
             $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
             cmp, $urandom, 26'($urandom), rt,
             $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
